// File: rtl/aibcr3_txdrv_seq.sv
// aibcr3_txdrv_seq
// Power/enable sequencer for one AIB TX analog driver slice. Holds the slice
// in POR after reset, then keeps the pad idle on its weak pulls until an
// enable request arrives. On enable it releases the weak pulls for one cycle,
// ramps the P/N drive-strength codes up one step at a time to the sampled
// targets, passes functional data while active, and ramps back down to zero
// before handing the pad back to the weak pulls. Every output is a flop so
// the analog cell never sees combinational glitches.

module aibcr3_txdrv_seq #(
  parameter int POR_CYC  = 16,
  parameter int STEP_CYC = 4,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       tx_en_req,
  input  logic [1:0] cfg_pdrv,
  input  logic [1:0] cfg_ndrv,
  input  logic       cfg_wkpu,
  input  logic       cfg_wkpd,
  input  logic       cfg_park,
  input  logic       tx_data,
  output logic       por,
  output logic       itx_en_buf,
  output logic [1:0] ipdrv_buf,
  output logic [1:0] indrv_buf,
  output logic       weak_pullupenb,
  output logic       weak_pulldownen,
  output logic       din,
  output logic       tx_ready,
  output logic       busy,
  output logic       cfg_err
);

  typedef enum logic [2:0] {
    ST_POR_HOLD,
    ST_IDLE,
    ST_BREAK,
    ST_RAMP_UP,
    ST_ACTIVE,
    ST_RAMP_DN,
    ST_RELEASE
  } state_e;

  // Timer reload values; the timer counts down to zero so a reload of N-1
  // gives an interval of N cycles.
  localparam logic [CNT_W-1:0] POR_LOAD  = CNT_W'(POR_CYC - 1);
  localparam logic [CNT_W-1:0] STEP_LOAD = CNT_W'(STEP_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       tgt_p_q, tgt_p_d;
  logic [1:0]       tgt_n_q, tgt_n_d;
  logic [1:0]       pdrv_q, pdrv_d;
  logic [1:0]       ndrv_q, ndrv_d;
  logic             por_q, por_d;
  logic             itx_en_q, itx_en_d;
  logic             wkpu_enb_q, wkpu_enb_d;
  logic             wkpd_en_q, wkpd_en_d;
  logic             din_q, din_d;
  logic             tx_ready_q, tx_ready_d;
  logic             busy_q, busy_d;
  logic             cfg_err_q, cfg_err_d;
  logic             timer_done;
  logic             codes_at_tgt;
  logic             codes_zero;

  assign timer_done   = (timer_q == '0);
  assign codes_at_tgt = (pdrv_q == tgt_p_q) && (ndrv_q == tgt_n_q);
  assign codes_zero   = (pdrv_q == 2'd0) && (ndrv_q == 2'd0);

  // Sequencer next state, step timer and drive-strength code stepping.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    tgt_p_d = tgt_p_q;
    tgt_n_d = tgt_n_q;
    pdrv_d  = pdrv_q;
    ndrv_d  = ndrv_q;
    case (state_q)
      ST_POR_HOLD: begin
        if (timer_done) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_IDLE: begin
        pdrv_d = 2'd0;
        ndrv_d = 2'd0;
        if (tx_en_req) begin
          state_d = ST_BREAK;
        end
      end
      ST_BREAK: begin
        tgt_p_d = cfg_pdrv;
        tgt_n_d = cfg_ndrv;
        timer_d = STEP_LOAD;
        state_d = ST_RAMP_UP;
      end
      ST_RAMP_UP: begin
        if (!tx_en_req) begin
          state_d = ST_RAMP_DN;
          timer_d = STEP_LOAD;
        end else if (timer_done) begin
          if (codes_at_tgt) begin
            state_d = ST_ACTIVE;
          end else begin
            if (pdrv_q < tgt_p_q) begin
              pdrv_d = pdrv_q + 2'd1;
            end
            if (ndrv_q < tgt_n_q) begin
              ndrv_d = ndrv_q + 2'd1;
            end
            timer_d = STEP_LOAD;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (!tx_en_req) begin
          state_d = ST_RAMP_DN;
          timer_d = STEP_LOAD;
        end
      end
      ST_RAMP_DN: begin
        if (timer_done) begin
          if (codes_zero) begin
            state_d = ST_RELEASE;
          end else begin
            if (pdrv_q != 2'd0) begin
              pdrv_d = pdrv_q - 2'd1;
            end
            if (ndrv_q != 2'd0) begin
              ndrv_d = ndrv_q - 2'd1;
            end
            timer_d = STEP_LOAD;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_POR_HOLD;
        timer_d = POR_LOAD;
        pdrv_d  = 2'd0;
        ndrv_d  = 2'd0;
      end
    endcase
  end

  // Output values decoded from the state being entered, so each output flop
  // changes on the same edge as the state it belongs to.
  always_comb begin
    por_d      = (state_d == ST_POR_HOLD);
    itx_en_d   = (state_d == ST_RAMP_UP) || (state_d == ST_ACTIVE) ||
                 (state_d == ST_RAMP_DN);
    tx_ready_d = (state_d == ST_ACTIVE);
    busy_d     = (state_d == ST_BREAK) || (state_d == ST_RAMP_UP) ||
                 (state_d == ST_RAMP_DN) || (state_d == ST_RELEASE);
    din_d      = 1'b0;
    case (state_d)
      ST_RAMP_UP, ST_RAMP_DN: din_d = cfg_park;
      ST_ACTIVE:              din_d = tx_data;
      default:                din_d = 1'b0;
    endcase
    // Weak pulls only track config while the pad stays idle; on every other
    // path they are released so they never fight the main driver. With both
    // pulls requested the pull-down wins.
    wkpu_enb_d = 1'b1;
    wkpd_en_d  = 1'b0;
    if ((state_q == ST_IDLE) && (state_d == ST_IDLE)) begin
      wkpu_enb_d = ~(cfg_wkpu & ~cfg_wkpd);
      wkpd_en_d  = cfg_wkpd;
    end
    cfg_err_d = cfg_err_q | ((state_q == ST_IDLE) & cfg_wkpu & cfg_wkpd);
  end

  // State, timer, codes and registered outputs; reset forces the slice back
  // into POR immediately without a ramp-down.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= ST_POR_HOLD;
      timer_q    <= POR_LOAD;
      tgt_p_q    <= 2'd0;
      tgt_n_q    <= 2'd0;
      pdrv_q     <= 2'd0;
      ndrv_q     <= 2'd0;
      por_q      <= 1'b1;
      itx_en_q   <= 1'b0;
      wkpu_enb_q <= 1'b1;
      wkpd_en_q  <= 1'b0;
      din_q      <= 1'b0;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      tgt_p_q    <= tgt_p_d;
      tgt_n_q    <= tgt_n_d;
      pdrv_q     <= pdrv_d;
      ndrv_q     <= ndrv_d;
      por_q      <= por_d;
      itx_en_q   <= itx_en_d;
      wkpu_enb_q <= wkpu_enb_d;
      wkpd_en_q  <= wkpd_en_d;
      din_q      <= din_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign por             = por_q;
  assign itx_en_buf      = itx_en_q;
  assign ipdrv_buf       = pdrv_q;
  assign indrv_buf       = ndrv_q;
  assign weak_pullupenb  = wkpu_enb_q;
  assign weak_pulldownen = wkpd_en_q;
  assign din             = din_q;
  assign tx_ready        = tx_ready_q;
  assign busy            = busy_q;
  assign cfg_err         = cfg_err_q;

endmodule

// File: tb/tb_aibcr3_txdrv_seq.sv
// Testbench for aibcr3_txdrv_seq: directed vector table for the main
// power-up / ramp / active / ramp-down flow, hand-written corner sequences,
// then randomized stimulus against a behavioural model.

module tb_aibcr3_txdrv_seq;

  localparam int POR = 16;
  localparam int STEP = 4;

  logic       clk = 1'b0;
  logic       rstb;
  logic       txEnReq;
  logic [1:0] cfgPdrv, cfgNdrv;
  logic       cfgWkpu, cfgWkpd, cfgPark, txData;
  logic       por, itxEnBuf, weakPullupenb, weakPulldownen, din, txReady, busy, cfgErr;
  logic [1:0] ipdrvBuf, indrvBuf;
  logic [12:0] dutVec;

  int checkCount = 0;
  int passCount = 0;
  logic sawReady;

  aibcr3_txdrv_seq #(.POR_CYC(POR), .STEP_CYC(STEP), .CNT_W(8)) dut (
    .clk(clk), .rstb(rstb), .tx_en_req(txEnReq), .cfg_pdrv(cfgPdrv), .cfg_ndrv(cfgNdrv),
    .cfg_wkpu(cfgWkpu), .cfg_wkpd(cfgWkpd), .cfg_park(cfgPark), .tx_data(txData),
    .por(por), .itx_en_buf(itxEnBuf), .ipdrv_buf(ipdrvBuf), .indrv_buf(indrvBuf),
    .weak_pullupenb(weakPullupenb), .weak_pulldownen(weakPulldownen), .din(din),
    .tx_ready(txReady), .busy(busy), .cfg_err(cfgErr)
  );

  always #5 clk = ~clk;

  assign dutVec = {por, itxEnBuf, ipdrvBuf, indrvBuf, weakPullupenb, weakPulldownen,
                   din, txReady, busy, cfgErr};

  // Expected-output packing: por, en, p, n, pu_enb, pd, din, ready, busy, err
  function automatic logic [12:0] mk(input logic po, input logic en, input logic [1:0] p,
                                     input logic [1:0] n, input logic pu, input logic pd,
                                     input logic d, input logic rdy, input logic bsy,
                                     input logic err);
    return {po, en, p, n, pu, pd, d, rdy, bsy, err};
  endfunction

  typedef struct {
    logic       req;
    logic [1:0] p;
    logic [1:0] n;
    logic       wkpu;
    logic       wkpd;
    logic       park;
    logic       data;
    int         cyc;
    logic [12:0] exp;
  } vec_t;

  vec_t table_q[$];

  task automatic applyStimulus(input logic req, input logic [1:0] p, input logic [1:0] n,
                               input logic wkpu, input logic wkpd, input logic park,
                               input logic data);
    txEnReq = req; cfgPdrv = p; cfgNdrv = n;
    cfgWkpu = wkpu; cfgWkpd = wkpd; cfgPark = park; txData = data;
  endtask

  task automatic checkOutput(input string name, input logic [12:0] got, input logic [12:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %b required %b (t=%0t)", name, got, exp, $time);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (txReady) sawReady = 1'b1;
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Codes are derived arithmetically from the cycles elapsed in a ramp phase.
  typedef enum int {M_POR, M_IDLE, M_BREAK, M_UP, M_ACTIVE, M_DN, M_RELEASE} mphase_t;
  mphase_t mPhase;
  int   mPorCnt, mEl, mTgtP, mTgtN, mStartP, mStartN;
  logic mPu, mPd, mDin, mErr;

  function automatic int minInt(input int a, input int b); return (a < b) ? a : b; endfunction
  function automatic int maxInt(input int a, input int b); return (a > b) ? a : b; endfunction

  function automatic int codeOf(input int tgt, input int start);
    case (mPhase)
      M_UP:     return minInt(tgt, mEl / STEP);
      M_ACTIVE: return tgt;
      M_DN:     return maxInt(0, start - mEl / STEP);
      default:  return 0;
    endcase
  endfunction

  function automatic logic [12:0] modelVec();
    logic en, bsy;
    en  = (mPhase == M_UP) || (mPhase == M_ACTIVE) || (mPhase == M_DN);
    bsy = (mPhase == M_BREAK) || (mPhase == M_UP) || (mPhase == M_DN) || (mPhase == M_RELEASE);
    return mk(mPhase == M_POR, en, 2'(codeOf(mTgtP, mStartP)), 2'(codeOf(mTgtN, mStartN)),
              mPu, mPd, mDin, mPhase == M_ACTIVE, bsy, mErr);
  endfunction

  task automatic modelReset();
    mPhase = M_POR; mPorCnt = 0; mEl = 0; mTgtP = 0; mTgtN = 0; mStartP = 0; mStartN = 0;
    mPu = 1'b1; mPd = 1'b0; mDin = 1'b0; mErr = 1'b0;
  endtask

  // Predicts the state after the coming clock edge from the inputs now driven.
  task automatic modelStep();
    case (mPhase)
      M_POR: begin
        mPorCnt++;
        if (mPorCnt == POR) mPhase = M_IDLE;
      end
      M_IDLE: begin
        if (cfgWkpu && cfgWkpd) mErr = 1'b1;
        if (txEnReq) begin
          mPhase = M_BREAK; mPu = 1'b1; mPd = 1'b0;
        end else begin
          mPu = !(cfgWkpu && !cfgWkpd); mPd = cfgWkpd;
        end
      end
      M_BREAK: begin
        mTgtP = cfgPdrv; mTgtN = cfgNdrv; mPhase = M_UP; mEl = 0; mDin = cfgPark;
      end
      M_UP: begin
        if (!txEnReq) begin
          mStartP = minInt(mTgtP, mEl / STEP); mStartN = minInt(mTgtN, mEl / STEP);
          mPhase = M_DN; mEl = 0; mDin = cfgPark;
        end else begin
          mEl++;
          if (mEl == (maxInt(mTgtP, mTgtN) + 1) * STEP) begin
            mPhase = M_ACTIVE; mDin = txData;
          end else mDin = cfgPark;
        end
      end
      M_ACTIVE: begin
        if (!txEnReq) begin
          mStartP = mTgtP; mStartN = mTgtN; mPhase = M_DN; mEl = 0; mDin = cfgPark;
        end else mDin = txData;
      end
      M_DN: begin
        mEl++; mDin = cfgPark;
        if (mEl == (maxInt(mStartP, mStartN) + 1) * STEP) begin
          mPhase = M_RELEASE; mDin = 1'b0;
        end
      end
      default: mPhase = M_IDLE;
    endcase
  endtask

  initial begin
    int prevP, prevN;
    logic prevValid, rstThisIter, invBad;
    int dp, dn;

    // Directed table: inputs applied, then after cyc cycles outputs compared.
    table_q.push_back('{0,3,2,0,1,0,0,15, mk(1,0,0,0,1,0,0,0,0,0)});
    table_q.push_back('{0,3,2,0,1,0,0, 1, mk(0,0,0,0,1,0,0,0,0,0)});
    table_q.push_back('{0,3,2,0,1,0,0, 1, mk(0,0,0,0,1,1,0,0,0,0)});
    table_q.push_back('{1,3,2,0,1,1,0, 1, mk(0,0,0,0,1,0,0,0,1,0)});
    table_q.push_back('{1,3,2,0,1,1,0, 1, mk(0,1,0,0,1,0,1,0,1,0)});
    table_q.push_back('{1,3,2,0,1,1,0, 3, mk(0,1,0,0,1,0,1,0,1,0)});
    table_q.push_back('{1,3,2,0,1,1,0, 1, mk(0,1,1,1,1,0,1,0,1,0)});
    table_q.push_back('{1,3,2,0,1,1,0, 4, mk(0,1,2,2,1,0,1,0,1,0)});
    table_q.push_back('{1,3,2,0,1,1,0, 4, mk(0,1,3,2,1,0,1,0,1,0)});
    table_q.push_back('{1,3,2,0,1,1,0, 3, mk(0,1,3,2,1,0,1,0,1,0)});
    table_q.push_back('{1,3,2,0,1,1,1, 1, mk(0,1,3,2,1,0,1,1,0,0)});
    table_q.push_back('{1,0,1,0,1,1,0, 1, mk(0,1,3,2,1,0,0,1,0,0)});
    table_q.push_back('{1,0,1,0,1,1,1, 1, mk(0,1,3,2,1,0,1,1,0,0)});
    table_q.push_back('{0,0,1,0,1,0,1, 1, mk(0,1,3,2,1,0,0,0,1,0)});
    table_q.push_back('{1,0,1,0,1,0,1, 4, mk(0,1,2,1,1,0,0,0,1,0)});
    table_q.push_back('{1,0,1,0,1,0,1, 4, mk(0,1,1,0,1,0,0,0,1,0)});
    table_q.push_back('{1,0,1,0,1,0,1, 4, mk(0,1,0,0,1,0,0,0,1,0)});
    table_q.push_back('{0,0,1,0,1,0,1, 3, mk(0,1,0,0,1,0,0,0,1,0)});
    table_q.push_back('{0,0,1,0,1,0,1, 1, mk(0,0,0,0,1,0,0,0,1,0)});
    table_q.push_back('{0,0,1,0,1,0,1, 1, mk(0,0,0,0,1,0,0,0,0,0)});
    table_q.push_back('{0,0,1,0,1,0,1, 1, mk(0,0,0,0,1,1,0,0,0,0)});
    table_q.push_back('{0,0,1,1,1,0,1, 1, mk(0,0,0,0,1,1,0,0,0,1)});
    table_q.push_back('{0,0,1,1,0,0,1, 1, mk(0,0,0,0,0,0,0,0,0,1)});

    rstb = 1'b0;
    applyStimulus(0, 2'd3, 2'd2, 0, 1, 0, 0);
    sawReady = 1'b0;
    tick(2);
    checkOutput("reset_state", dutVec, mk(1,0,0,0,1,0,0,0,0,0));
    rstb = 1'b1;

    foreach (table_q[i]) begin
      applyStimulus(table_q[i].req, table_q[i].p, table_q[i].n, table_q[i].wkpu,
                    table_q[i].wkpd, table_q[i].park, table_q[i].data);
      tick(table_q[i].cyc);
      checkOutput($sformatf("vec%0d", i), dutVec, table_q[i].exp);
    end

    // Enable dropped mid ramp-up with p code at 1: ramp-down, no tx_ready.
    sawReady = 1'b0;
    applyStimulus(1, 2'd1, 2'd0, 1, 0, 1, 0);
    tick(1); checkOutput("abort_break", dutVec, mk(0,0,0,0,1,0,0,0,1,1));
    tick(1); checkOutput("abort_up0",   dutVec, mk(0,1,0,0,1,0,1,0,1,1));
    tick(4); checkOutput("abort_up1",   dutVec, mk(0,1,1,0,1,0,1,0,1,1));
    txEnReq = 1'b0;
    tick(1); checkOutput("abort_dn",    dutVec, mk(0,1,1,0,1,0,1,0,1,1));
    tick(4); checkOutput("abort_dn0",   dutVec, mk(0,1,0,0,1,0,1,0,1,1));
    tick(4); checkOutput("abort_rel",   dutVec, mk(0,0,0,0,1,0,0,0,1,1));
    tick(1); checkOutput("abort_idle",  dutVec, mk(0,0,0,0,1,0,0,0,0,1));
    tick(1); checkOutput("abort_pull",  dutVec, mk(0,0,0,0,0,0,0,0,0,1));
    checkOutput("abort_no_ready", {12'd0, sawReady}, 13'd0);

    // Async reset while ACTIVE, then POR hold restarts.
    applyStimulus(1, 2'd0, 2'd0, 1, 0, 0, 1);
    tick(1); checkOutput("act_break", dutVec, mk(0,0,0,0,1,0,0,0,1,1));
    tick(1); checkOutput("act_up",    dutVec, mk(0,1,0,0,1,0,0,0,1,1));
    tick(4); checkOutput("act_on",    dutVec, mk(0,1,0,0,1,0,1,1,0,1));
    #2 rstb = 1'b0;
    #1 checkOutput("async_reset", dutVec, mk(1,0,0,0,1,0,0,0,0,0));
    @(negedge clk);
    rstb = 1'b1;
    applyStimulus(0, 2'd0, 2'd0, 0, 0, 0, 0);
    tick(15); checkOutput("por_hold", dutVec, mk(1,0,0,0,1,0,0,0,0,0));
    tick(1);  checkOutput("por_done", dutVec, mk(0,0,0,0,1,0,0,0,0,0));

    // Randomized run against the model.
    rstb = 1'b0;
    modelReset();
    tick(1);
    prevValid = 1'b0; prevP = 0; prevN = 0;
    for (int c = 0; c < 4000; c++) begin
      rstThisIter = 1'b0;
      if (!rstb) rstb = 1'b1;
      else if ($urandom_range(0, 499) == 0) begin
        rstb = 1'b0; rstThisIter = 1'b1;
      end
      if ($urandom_range(0, 29) == 0) txEnReq = ~txEnReq;
      cfgPdrv = 2'($urandom_range(0, 3));
      cfgNdrv = 2'($urandom_range(0, 3));
      cfgWkpd = 1'($urandom_range(0, 1));
      cfgWkpu = 1'($urandom_range(0, 1));
      if (cfgWkpu && cfgWkpd && $urandom_range(0, 7) != 0) cfgWkpu = 1'b0;
      cfgPark = 1'($urandom_range(0, 1));
      txData  = 1'($urandom_range(0, 1));
      if (!rstb) modelReset(); else modelStep();
      @(negedge clk);
      checkOutput($sformatf("random%0d", c), dutVec, modelVec());
      invBad = (itxEnBuf && (!weakPullupenb || weakPulldownen)) ||
               (!itxEnBuf && (ipdrvBuf != 2'd0 || indrvBuf != 2'd0)) ||
               (por && itxEnBuf);
      dp = int'(ipdrvBuf) - prevP;
      dn = int'(indrvBuf) - prevN;
      if (prevValid && !rstThisIter && (dp > 1 || dp < -1 || dn > 1 || dn < -1)) invBad = 1'b1;
      checkOutput($sformatf("invariant%0d", c), {12'd0, invBad}, 13'd0);
      prevP = int'(ipdrvBuf); prevN = int'(indrvBuf); prevValid = 1'b1;
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/aibcr3_txdrv_seq.md
Name: aibcr3_txdrv_seq

Overview:
- Synchronous power/enable sequencer for one AIB TX analog driver slice.
- Generates the slice's POR, tx-enable, 2-bit P/N drive-strength codes, weak pull-up/pull-down controls and gated data.
- Ramps drive strength one step at a time. Never lets the weak pulls fight the main driver.
- Sits between the per-pin config/adapter logic and the TX analog cell, one instance per TX pad.

Parameters:
- POR_CYC, 16, cycles POR stays asserted after rstb deasserts (≥1).
- STEP_CYC, 4, cycles per drive-strength step (≥1).
- CNT_W, 8, timer width; must hold max(POR_CYC, STEP_CYC)-1.

Ports:
- clk  input  1  sequencer clock
- rstb  input  1  async active-low reset
- tx_en_req  input  1  level request to drive pad (clk-synchronous)
- cfg_pdrv  input  2  target P drive strength, 0..3
- cfg_ndrv  input  2  target N drive strength, 0..3
- cfg_wkpu  input  1  weak pull-up wanted while idle
- cfg_wkpd  input  1  weak pull-down wanted while idle
- cfg_park  input  1  data level driven while enabled but not ACTIVE
- tx_data  input  1  functional data
- por  output  1  power-on reset to analog slice
- itx_en_buf  output  1  driver enable
- ipdrv_buf  output  2  current P strength code
- indrv_buf  output  2  current N strength code
- weak_pullupenb  output  1  weak pull-up enable, active-low
- weak_pulldownen  output  1  weak pull-down enable
- din  output  1  data to driver
- tx_ready  output  1  high only in ACTIVE
- busy  output  1  high in BREAK, RAMP_UP, RAMP_DN, RELEASE
- cfg_err  output  1  sticky; set when cfg_wkpu & cfg_wkpd seen in IDLE

Behaviour:
- All outputs registered.
- Reset values: por=1, itx_en_buf=0, ipdrv_buf=0, indrv_buf=0, weak_pullupenb=1, weak_pulldownen=0, din=0, tx_ready=0, busy=0, cfg_err=0, state=POR_HOLD, timer=POR_CYC-1.
- Reset asserted mid-operation returns to these values immediately (async). No ramp-down is performed.
- POR_HOLD:
  - por=1; timer decrements each cycle.
  - At timer==0, next edge: por=0, state=IDLE.
- IDLE:
  - itx_en_buf=0, strengths 0, din=0.
  - Weak pulls follow config each cycle: weak_pullupenb=~cfg_wkpu, weak_pulldownen=cfg_wkpd.
  - If both cfg_wkpu and cfg_wkpd are set: pull-down wins (weak_pullupenb=1, weak_pulldownen=1) and cfg_err sets.
  - tx_en_req=1 → BREAK.
- BREAK (1 cycle):
  - Weak pulls released (weak_pullupenb=1, weak_pulldownen=0); itx_en_buf stays 0.
  - cfg_pdrv/cfg_ndrv sampled into target registers.
  - Next state RAMP_UP with timer=STEP_CYC-1.
- RAMP_UP:
  - itx_en_buf=1, din=cfg_park; timer decrements.
  - On expiry, if both current codes equal their targets → ACTIVE.
  - Otherwise each code below its target increments by 1 (codes move independently) and the timer reloads.
  - ACTIVE is entered (max(tgt_p,tgt_n)+1)*STEP_CYC cycles after RAMP_UP entry.
  - tx_en_req=0 at any cycle → RAMP_DN from current codes, timer reloaded.
- ACTIVE:
  - tx_ready=1; din=tx_data registered (1-cycle latency).
  - cfg_pdrv/ndrv changes are ignored until the next enable.
  - tx_en_req=0 → RAMP_DN, timer reloaded, tx_ready=0 on the same edge.
- RAMP_DN:
  - din=cfg_park; timer decrements.
  - On expiry, if both codes are 0 → RELEASE; else each nonzero code decrements by 1 and the timer reloads.
  - tx_en_req reasserting is ignored until IDLE is reached. The down-ramp always completes.
- RELEASE (1 cycle): itx_en_buf=0, weak pulls still released; next state IDLE.
- Invariants, checked in verification:
  - Weak pull never enabled while itx_en_buf=1.
  - Strength codes change by at most 1 per step.
  - Codes are 0 whenever itx_en_buf=0.
  - por=1 implies itx_en_buf=0.
- cfg_err clears only on reset.

Test Plan:
- Reset release, POR_CYC=16 → por=1 for 16 cycles after rstb rise, then IDLE; weak_pulldownen follows cfg_wkpd=1 on the next cycle.
- tx_en_req=1 with targets p=3/n=2, STEP_CYC=4 → BREAK 1 cycle; codes step p:0→1→2→3 and n:0→1→2 every 4 cycles; tx_ready rises 16 cycles after RAMP_UP entry.
- In ACTIVE, toggle tx_data 1,0,1 → din shows 1,0,1 one cycle later; drop tx_en_req → codes decrement to 0 every 4 cycles, RELEASE, itx_en_buf=0, then weak pulls return.
- Drop tx_en_req when p code=1 mid RAMP_UP → immediate RAMP_DN; p returns to 0 within 2 steps; tx_ready never asserts.
- cfg_wkpu=1 and cfg_wkpd=1 in IDLE → weak_pulldownen=1, weak_pullupenb=1, cfg_err=1 and stays sticky after cfg is fixed.
- Assert rstb=0 during ACTIVE → all outputs at reset values asynchronously; POR_HOLD sequence restarts on release.
